// File: rtl/fregfile_sb_pkg.sv
// Shared constants for the floating-point register file and its scoreboard.
// The canonical single NaN lives here so the FPU and register file agree on it.
package fp_rf_pkg;

    localparam int SCALE_DEF = 5;
    localparam int WIDTH_DEF = 32;
    localparam int NREAD_DEF = 3;

    localparam int          FLEN_S      = 32;
    localparam logic [31:0] NAN_BOX_HI  = 32'hFFFF_FFFF;
    localparam logic [31:0] CANON_NAN_S = 32'h7FC0_0000;

    // A single-precision value held in a 64-bit register has its upper half all ones.
    function automatic logic [63:0] nanBox(input logic [FLEN_S-1:0] single);
        return {NAN_BOX_HI, single};
    endfunction

endpackage

// File: rtl/fregfile_sb_if.sv
// Read, write and issue signals between the decode/writeback stages and the FP register file.
interface fregfile_sb_if
    import fp_rf_pkg::*;
#(
    parameter int SCALE = SCALE_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREAD = NREAD_DEF
) ();

    logic [NREAD*SCALE-1:0] ra;
    logic [NREAD*WIDTH-1:0] rd;
    logic [NREAD-1:0]       rbusy;
    logic                   we;
    logic [SCALE-1:0]       wa;
    logic [WIDTH-1:0]       wd;
    logic                   wsingle;
    logic                   iss_valid;
    logic [SCALE-1:0]       iss_rd;
    logic                   iss_ready;

    modport master (
        output ra, we, wa, wd, wsingle, iss_valid, iss_rd,
        input  rd, rbusy, iss_ready
    );

    modport slave (
        input  ra, we, wa, wd, wsingle, iss_valid, iss_rd,
        output rd, rbusy, iss_ready
    );

endinterface

// File: rtl/fregfile_sb_scoreboard.sv
// Per-register busy bits for in-flight multi-cycle FP operations.
// Drives issue acceptance and the per-read-port hazard flags.
module fp_scoreboard
    import fp_rf_pkg::*;
#(
    parameter int SCALE = SCALE_DEF,
    parameter int NREAD = NREAD_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREAD*SCALE-1:0] ra_i,
    input  logic                   we_i,
    input  logic [SCALE-1:0]       wa_i,
    input  logic                   issValid_i,
    input  logic [SCALE-1:0]       issRd_i,
    output logic                   issReady_o,
    output logic [NREAD-1:0]       rbusy_o
);

    localparam int NREG = 2**SCALE;

    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [SCALE-1:0] portAddr;

    // A writeback landing this cycle frees its register, so a WAW issue onto it may proceed.
    assign issReady_o = !busy_q[issRd_i] || (we_i && (wa_i == issRd_i));

    always_comb begin
        busy_d = busy_q;
        if (we_i) begin
            busy_d[wa_i] = 1'b0;
        end
        if (issValid_i && issReady_o) begin
            busy_d[issRd_i] = 1'b1;
        end
    end

    always_comb begin
        rbusy_o  = '0;
        portAddr = '0;
        for (int i = 0; i < NREAD; i++) begin
            portAddr   = ra_i[i*SCALE +: SCALE];
            rbusy_o[i] = busy_q[portAddr] && !(we_i && (wa_i == portAddr));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/fregfile_sb.sv
// Floating-point register file: NREAD combinational read ports, one bypassed write port,
// NaN-boxing of single results in 64-bit mode, and a busy scoreboard for multi-cycle ops.
module fregfile_sb
    import fp_rf_pkg::*;
#(
    parameter int SCALE = SCALE_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREAD = NREAD_DEF
) (
    input  logic         clk,
    input  logic         rst,
    fregfile_sb_if.slave bus
);

    localparam int NREG = 2**SCALE;

    logic [WIDTH-1:0] regFile_q [NREG];
    logic [WIDTH-1:0] writeData;
    logic [SCALE-1:0] readAddr;

    // Boxing is applied before both storage and bypass so the two paths always agree.
    generate
        if (WIDTH == 64) begin : g_box
            assign writeData = bus.wsingle ? nanBox(bus.wd[FLEN_S-1:0]) : bus.wd;
        end else begin : g_nobox
            assign writeData = bus.wd;
        end
    endgenerate

    always_comb begin
        bus.rd   = '0;
        readAddr = '0;
        for (int i = 0; i < NREAD; i++) begin
            readAddr = bus.ra[i*SCALE +: SCALE];
            if (bus.we && (bus.wa == readAddr)) begin
                bus.rd[i*WIDTH +: WIDTH] = writeData;
            end else begin
                bus.rd[i*WIDTH +: WIDTH] = regFile_q[readAddr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NREG; j++) begin
                regFile_q[j] <= '0;
            end
        end else if (bus.we) begin
            regFile_q[bus.wa] <= writeData;
        end
    end

    fp_scoreboard #(
        .SCALE (SCALE),
        .NREAD (NREAD)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .ra_i       (bus.ra),
        .we_i       (bus.we),
        .wa_i       (bus.wa),
        .issValid_i (bus.iss_valid),
        .issRd_i    (bus.iss_rd),
        .issReady_o (bus.iss_ready),
        .rbusy_o    (bus.rbusy)
    );

endmodule

// File: tb/tb_fregfile_sb.sv
// Self-checking bench for fregfile_sb: a 32-bit instance driven from a vector table
// plus hand sequences for async reset and a 64-bit instance for NaN-boxing.
module tb_fregfile_sb;
    import fp_rf_pkg::*;

    logic clk;
    logic rst;

    fregfile_sb_if #(.SCALE(5), .WIDTH(32), .NREAD(3)) bus32 ();
    fregfile_sb_if #(.SCALE(5), .WIDTH(64), .NREAD(3)) bus64 ();

    fregfile_sb #(.SCALE(5), .WIDTH(32), .NREAD(3)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    fregfile_sb #(.SCALE(5), .WIDTH(64), .NREAD(3)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        issValid;
        logic [4:0]  issRd;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [2:0]  expRbusy;
        logic        expReady;
    } vecT;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] value;
    } expT;

    localparam int NVEC = 15;

    vecT vecs [NVEC];
    expT expQ [$];
    int  compared   = 0;
    int  mismatched = 0;

    // Selectors 0-4 address the 32-bit instance, 5-9 the 64-bit one.
    function automatic logic [63:0] actualOf(input int sel);
        case (sel)
            0, 1, 2: return {32'b0, bus32.rd[sel*32 +: 32]};
            3:       return {61'b0, bus32.rbusy};
            4:       return {63'b0, bus32.iss_ready};
            5, 6, 7: return bus64.rd[(sel-5)*64 +: 64];
            8:       return {61'b0, bus64.rbusy};
            default: return {63'b0, bus64.iss_ready};
        endcase
    endfunction

    task automatic pushExp(input string tag, input int sel, input logic [63:0] value);
        expT e;
        e.tag   = tag;
        e.sel   = sel;
        e.value = value;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        expT         e;
        logic [63:0] act;
        while (expQ.size() > 0) begin
            e   = expQ.pop_front();
            act = actualOf(e.sel);
            compared++;
            if (act !== e.value) begin
                mismatched++;
                $display("[TB] FAIL %s: got %h, expected %h", e.tag, act, e.value);
            end
        end
    endtask

    task automatic setIdle();
        bus32.ra = '0; bus32.we = 1'b0; bus32.wa = '0; bus32.wd = '0;
        bus32.wsingle = 1'b0; bus32.iss_valid = 1'b0; bus32.iss_rd = '0;
        bus64.ra = '0; bus64.we = 1'b0; bus64.wa = '0; bus64.wd = '0;
        bus64.wsingle = 1'b0; bus64.iss_valid = 1'b0; bus64.iss_rd = '0;
    endtask

    task automatic applyStimulus(input int idx, input vecT v);
        @(negedge clk);
        bus32.we        = v.we;
        bus32.wa        = v.wa;
        bus32.wd        = v.wd;
        bus32.ra        = {v.ra2, v.ra1, v.ra0};
        bus32.iss_valid = v.issValid;
        bus32.iss_rd    = v.issRd;
        pushExp($sformatf("v%0d.rd0", idx), 0, {32'b0, v.exp0});
        pushExp($sformatf("v%0d.rd1", idx), 1, {32'b0, v.exp1});
        pushExp($sformatf("v%0d.rd2", idx), 2, {32'b0, v.exp2});
        pushExp($sformatf("v%0d.rbusy", idx), 3, {61'b0, v.expRbusy});
        pushExp($sformatf("v%0d.iss_ready", idx), 4, {63'b0, v.expReady});
        #2;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //            we   wa    wd             ra0   ra1   ra2   iv    ird   exp0           exp1           exp2           rbusy   rdy
        vecs[0]  = '{1'b1, 5'd2, 32'h3F80_0000, 5'd2, 5'd0, 5'd0, 1'b0, 5'd0, 32'h3F80_0000, 32'h0,         32'h0,         3'b000, 1'b1};
        vecs[1]  = '{1'b1, 5'd4, 32'h4000_0000, 5'd2, 5'd2, 5'd4, 1'b0, 5'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000, 1'b1};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,         5'd2, 5'd2, 5'd4, 1'b0, 5'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000, 1'b1};
        vecs[3]  = '{1'b1, 5'd0, 32'h4040_0000, 5'd0, 5'd2, 5'd4, 1'b0, 5'd0, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000, 1'b1};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd4, 5'd2, 1'b0, 5'd0, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000, 3'b000, 1'b1};
        vecs[5]  = '{1'b1, 5'd5, 32'h4080_0000, 5'd5, 5'd5, 5'd3, 1'b0, 5'd0, 32'h4080_0000, 32'h4080_0000, 32'h0,         3'b000, 1'b1};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,         5'd4, 5'd1, 5'd2, 1'b1, 5'd4, 32'h4000_0000, 32'h0,         32'h3F80_0000, 3'b000, 1'b1};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,         5'd5, 5'd4, 5'd4, 1'b1, 5'd4, 32'h4080_0000, 32'h4000_0000, 32'h4000_0000, 3'b110, 1'b0};
        vecs[8]  = '{1'b1, 5'd4, 32'h4100_0000, 5'd4, 5'd4, 5'd6, 1'b0, 5'd4, 32'h4100_0000, 32'h4100_0000, 32'h0,         3'b000, 1'b1};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,         5'd2, 5'd4, 5'd5, 1'b0, 5'd4, 32'h3F80_0000, 32'h4100_0000, 32'h4080_0000, 3'b000, 1'b1};
        vecs[10] = '{1'b1, 5'd7, 32'h4110_0000, 5'd7, 5'd4, 5'd0, 1'b1, 5'd7, 32'h4110_0000, 32'h4100_0000, 32'h4040_0000, 3'b000, 1'b1};
        vecs[11] = '{1'b0, 5'd0, 32'h0,         5'd7, 5'd0, 5'd7, 1'b0, 5'd7, 32'h4110_0000, 32'h4040_0000, 32'h4110_0000, 3'b101, 1'b0};
        vecs[12] = '{1'b1, 5'd7, 32'h4120_0000, 5'd7, 5'd7, 5'd2, 1'b1, 5'd7, 32'h4120_0000, 32'h4120_0000, 32'h3F80_0000, 3'b000, 1'b1};
        vecs[13] = '{1'b0, 5'd0, 32'h0,         5'd7, 5'd7, 5'd1, 1'b0, 5'd7, 32'h4120_0000, 32'h4120_0000, 32'h0,         3'b011, 1'b0};
        vecs[14] = '{1'b1, 5'd3, 32'h4130_0000, 5'd3, 5'd7, 5'd4, 1'b1, 5'd7, 32'h4130_0000, 32'h4120_0000, 32'h4100_0000, 3'b010, 1'b0};

        rst = 1'b0;
        setIdle();
        bus32.ra = {5'd9, 5'd4, 5'd2};
        bus64.ra = {5'd9, 5'd4, 5'd2};
        #1 rst = 1'b1;
        #1;
        pushExp("reset.rd0", 0, 64'h0);
        pushExp("reset.rd1", 1, 64'h0);
        pushExp("reset.rd2", 2, 64'h0);
        pushExp("reset.rbusy", 3, 64'h0);
        pushExp("reset.iss_ready", 4, 64'h1);
        pushExp("reset64.rd0", 5, 64'h0);
        pushExp("reset64.rbusy", 8, 64'h0);
        pushExp("reset64.iss_ready", 9, 64'h1);
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(i, vecs[i]);
            checkOutput();
        end

        // f7 still has a pending writer; an async reset pulse between edges must discard it.
        @(negedge clk);
        setIdle();
        bus32.ra     = {5'd3, 5'd0, 5'd7};
        bus32.iss_rd = 5'd7;
        #1;
        pushExp("preReset.rbusy", 3, 64'h1);
        pushExp("preReset.iss_ready", 4, 64'h0);
        checkOutput();
        rst = 1'b1;
        #1;
        pushExp("midReset.rd0", 0, 64'h0);
        pushExp("midReset.rd2", 2, 64'h0);
        pushExp("midReset.rbusy", 3, 64'h0);
        pushExp("midReset.iss_ready", 4, 64'h1);
        checkOutput();
        rst = 1'b0;

        @(negedge clk);
        bus32.we = 1'b1; bus32.wa = 5'd7; bus32.wd = 32'h4150_0000;
        #2;
        pushExp("postReset.bypass", 0, 64'h4150_0000);
        pushExp("postReset.rbusy", 3, 64'h0);
        checkOutput();
        @(negedge clk);
        bus32.we = 1'b0; bus32.wsingle = 1'b1;
        #2;
        pushExp("postReset.stored", 0, 64'h4150_0000);
        pushExp("postReset.iss_ready", 4, 64'h1);
        checkOutput();

        // 64-bit instance: a single write is boxed on both the bypass and the stored path.
        @(negedge clk);
        bus32.wsingle = 1'b0;
        bus64.we = 1'b1; bus64.wa = 5'd1; bus64.wsingle = 1'b1;
        bus64.wd = 64'h0123_4567_3F80_0000;
        bus64.ra = {5'd0, 5'd0, 5'd1};
        #2;
        pushExp("box.bypass", 5, 64'hFFFF_FFFF_3F80_0000);
        checkOutput();
        @(negedge clk);
        bus64.wa = 5'd2; bus64.wsingle = 1'b0;
        bus64.wd = 64'h0123_4567_89AB_CDEF;
        bus64.ra = {5'd0, 5'd2, 5'd1};
        #2;
        pushExp("box.stored", 5, 64'hFFFF_FFFF_3F80_0000);
        pushExp("double.bypass", 6, 64'h0123_4567_89AB_CDEF);
        checkOutput();
        @(negedge clk);
        bus64.we = 1'b0;
        bus64.ra = {5'd1, 5'd2, 5'd0};
        #2;
        pushExp("double.stored", 6, 64'h0123_4567_89AB_CDEF);
        pushExp("box.port2", 7, 64'hFFFF_FFFF_3F80_0000);
        pushExp("zero64.port0", 5, 64'h0);
        checkOutput();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
